// File: rtl/fetch_pc_ctrl.sv
// Program-counter and fetch-control unit: increment, stall, PC-relative branch,
// absolute jump and call/return through a small return-address stack.
module fetch_pc_ctrl #(
    parameter int PC_W      = 10,
    parameter int OFF_W     = 8,
    parameter int HALT_PC   = 63,
    parameter int RAS_DEPTH = 4
) (
    input  logic                               CLK,
    input  logic                               init,
    input  logic                               stall,
    input  logic                               branch_en,
    input  logic                               bSIGN,
    input  logic [OFF_W-1:0]                   bOFFSET,
    input  logic                               jump_en,
    input  logic                               call_en,
    input  logic                               ret_en,
    input  logic [PC_W-1:0]                    jTARGET,
    output logic [PC_W-1:0]                    PC,
    output logic                               halt,
    output logic                               ras_err,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             halt_q, halt_d;
    logic             ras_err_q, ras_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  ras_top;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];

    assign pc_inc = pc_q + PC_W'(1);

    // Entry i holds the return address pushed when occupancy was i.
    always_comb begin
        ras_top = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (cnt_q == CNT_W'(i + 1)) ras_top = ras_q[i];
        end
    end

    always_comb begin
        pc_d      = pc_q;
        halt_d    = halt_q;
        ras_err_d = ras_err_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        if (!halt_q) begin
            if (pc_q > PC_W'(HALT_PC)) begin
                halt_d = 1'b1;
            end else if (!stall) begin
                if (ret_en) begin
                    if (cnt_q == '0) begin
                        ras_err_d = 1'b1;
                        halt_d    = 1'b1;
                    end else begin
                        pc_d  = ras_top;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else if (call_en) begin
                    if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                        ras_err_d = 1'b1;
                        halt_d    = 1'b1;
                    end else begin
                        push  = 1'b1;
                        pc_d  = jTARGET;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (jump_en) begin
                    pc_d = jTARGET;
                end else if (branch_en) begin
                    // Offset is an unsigned magnitude; wrap-around is intended.
                    pc_d = bSIGN ? pc_q - PC_W'(bOFFSET) : pc_q + PC_W'(bOFFSET);
                end else begin
                    pc_d = pc_inc;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge init) begin
        if (init) begin
            pc_q      <= '0;
            halt_q    <= 1'b0;
            ras_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            halt_q    <= halt_d;
            ras_err_q <= ras_err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Stack storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (push && cnt_q == CNT_W'(i)) ras_q[i] <= pc_inc;
        end
    end

    assign PC        = pc_q;
    assign halt      = halt_q;
    assign ras_err   = ras_err_q;
    assign ras_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based model of the fetch rules.
module tb_fetch_pc_ctrl;

    localparam int PC_W      = 10;
    localparam int OFF_W     = 8;
    localparam int HALT_PC   = 63;
    localparam int RAS_DEPTH = 4;
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1);
    localparam int PC_MOD    = 1 << PC_W;

    logic             CLK;
    logic             init;
    logic             stall;
    logic             branch_en;
    logic             bSIGN;
    logic [OFF_W-1:0] bOFFSET;
    logic             jump_en;
    logic             call_en;
    logic             ret_en;
    logic [PC_W-1:0]  jTARGET;
    logic [PC_W-1:0]  PC;
    logic             halt;
    logic             ras_err;
    logic [CNT_W-1:0] ras_count;

    fetch_pc_ctrl #(
        .PC_W(PC_W), .OFF_W(OFF_W), .HALT_PC(HALT_PC), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .CLK(CLK), .init(init), .stall(stall), .branch_en(branch_en),
        .bSIGN(bSIGN), .bOFFSET(bOFFSET), .jump_en(jump_en), .call_en(call_en),
        .ret_en(ret_en), .jTARGET(jTARGET), .PC(PC), .halt(halt),
        .ras_err(ras_err), .ras_count(ras_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pc;
    bit m_halt;
    bit m_err;
    int m_ras[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; branch_en = 0; bSIGN = 0; bOFFSET = '0;
        jump_en = 0; call_en = 0; ret_en = 0; jTARGET = '0;
    endtask

    task automatic model_reset();
        m_pc = 0; m_halt = 0; m_err = 0;
        m_ras.delete();
    endtask

    task automatic model_step();
        int off;
        off = int'(bOFFSET);
        if (m_halt) begin
        end else if (m_pc > HALT_PC) begin
            m_halt = 1;
        end else if (stall) begin
        end else if (ret_en) begin
            if (m_ras.size() == 0) begin
                m_err = 1; m_halt = 1;
            end else begin
                m_pc = m_ras.pop_back();
            end
        end else if (call_en) begin
            if (m_ras.size() == RAS_DEPTH) begin
                m_err = 1; m_halt = 1;
            end else begin
                m_ras.push_back((m_pc + 1) % PC_MOD);
                m_pc = int'(jTARGET);
            end
        end else if (jump_en) begin
            m_pc = int'(jTARGET);
        end else if (branch_en) begin
            m_pc = bSIGN ? (m_pc - off + PC_MOD) % PC_MOD : (m_pc + off) % PC_MOD;
        end else begin
            m_pc = (m_pc + 1) % PC_MOD;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_pc"},    32'(PC),        32'(m_pc));
        check({tag, "_halt"},  32'(halt),      32'(m_halt));
        check({tag, "_err"},   32'(ras_err),   32'(m_err));
        check({tag, "_count"}, 32'(ras_count), 32'(m_ras.size()));
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        compare_all("step");
    endtask

    // Reset is raised mid-cycle to exercise its asynchronous behaviour.
    task automatic do_reset();
        @(posedge CLK);
        #3;
        init = 1'b1;
        #1;
        model_reset();
        compare_all("reset");
        @(negedge CLK);
        init = 1'b0;
        clear_inputs();
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) cycle();
    endtask

    task automatic random_inputs();
        clear_inputs();
        stall     = ($urandom % 8) == 0;
        ret_en    = ($urandom % 6) == 0;
        call_en   = ($urandom % 5) == 0;
        jump_en   = ($urandom % 8) == 0;
        branch_en = ($urandom % 4) == 0;
        bSIGN     = $urandom % 2;
        bOFFSET   = (($urandom % 10) == 0) ? OFF_W'($urandom) : OFF_W'($urandom_range(0, 20));
        jTARGET   = (($urandom % 10) == 0) ? PC_W'($urandom) : PC_W'($urandom_range(0, 70));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        init = 1'b0;
        clear_inputs();

        // Reset then free increment
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cycle();
            check("inc_pc", 32'(PC), 32'(i));
        end
        check("inc_halt", 32'(halt), 32'd0);

        // Backward branch wraps; the wrapped PC is beyond HALT_PC so halt follows
        do_reset();
        idle(3);
        branch_en = 1; bSIGN = 1; bOFFSET = 8'd5;
        cycle();
        check("br_back_pc", 32'(PC), 32'd1022);
        clear_inputs();
        cycle();
        check("br_wrap_halt", 32'(halt), 32'd1);
        check("br_wrap_pc", 32'(PC), 32'd1022);

        do_reset();
        idle(3);
        branch_en = 1; bSIGN = 0; bOFFSET = 8'd4;
        cycle();
        check("br_fwd_pc", 32'(PC), 32'd7);

        // Halt past HALT_PC
        do_reset();
        idle(64);
        check("halt_pc64", 32'(PC), 32'd64);
        check("halt_not_yet", 32'(halt), 32'd0);
        cycle();
        check("halt_set", 32'(halt), 32'd1);
        for (int i = 0; i < 10; i++) begin
            random_inputs();
            stall = 0; ret_en = 0;
            cycle();
            check("halt_frozen_pc", 32'(PC), 32'd64);
        end
        do_reset();
        check("halt_cleared", 32'(halt), 32'd0);

        // Nested call/return
        do_reset();
        idle(10);
        call_en = 1; jTARGET = 10'd40;
        cycle();
        check("call1_pc", 32'(PC), 32'd40);
        check("call1_cnt", 32'(ras_count), 32'd1);
        idle(1);
        call_en = 1; jTARGET = 10'd50;
        cycle();
        check("call2_pc", 32'(PC), 32'd50);
        check("call2_cnt", 32'(ras_count), 32'd2);
        clear_inputs();
        ret_en = 1;
        cycle();
        check("ret1_pc", 32'(PC), 32'd42);
        cycle();
        check("ret2_pc", 32'(PC), 32'd11);
        check("ret2_cnt", 32'(ras_count), 32'd0);

        // Underflow
        do_reset();
        idle(7);
        ret_en = 1;
        cycle();
        check("uflow_err", 32'(ras_err), 32'd1);
        check("uflow_halt", 32'(halt), 32'd1);
        check("uflow_pc", 32'(PC), 32'd7);

        // Overflow on the push beyond RAS_DEPTH
        do_reset();
        for (int k = 0; k < RAS_DEPTH; k++) begin
            clear_inputs();
            call_en = 1; jTARGET = PC_W'(10 + 10 * k);
            cycle();
        end
        check("oflow_full_err", 32'(ras_err), 32'd0);
        cycle();
        check("oflow_err", 32'(ras_err), 32'd1);
        check("oflow_halt", 32'(halt), 32'd1);
        check("oflow_cnt", 32'(ras_count), 32'd4);
        check("oflow_pc", 32'(PC), 32'd40);

        // Stall dominance and request priority
        do_reset();
        idle(2);
        call_en = 1; jTARGET = 10'd20;
        cycle();
        stall = 1; branch_en = 1; call_en = 1; bOFFSET = 8'd3; jTARGET = 10'd30;
        repeat (3) begin
            cycle();
            check("stall_pc", 32'(PC), 32'd20);
            check("stall_cnt", 32'(ras_count), 32'd1);
        end
        clear_inputs();
        ret_en = 1; call_en = 1; jump_en = 1; jTARGET = 10'd33;
        cycle();
        check("prio_ret_pc", 32'(PC), 32'd3);
        check("prio_ret_cnt", 32'(ras_count), 32'd0);
        clear_inputs();
        jump_en = 1; branch_en = 1; jTARGET = 10'd25; bOFFSET = 8'd9;
        cycle();
        check("prio_jump_pc", 32'(PC), 32'd25);

        // Randomized traffic
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            repeat ($urandom_range(20, 60)) begin
                if (($urandom % 60) == 0) do_reset();
                random_inputs();
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
